// File: rtl/gpu_frame_capture.sv
// Double-banked framebuffer sink for the GPU pixel stream, with clipping and a 1-cycle read port.
// Optional clip/drop statistics outputs are enabled by defining GPU_CAPTURE_STATS_EN.
module gpu_frame_capture #(
    parameter int H_RES   = 800,
    parameter int V_RES   = 600,
    parameter int COLOR_W = 8,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 19,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               pixel_valid,
    input  logic               pixel_draw,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COLOR_W-1:0] pixel_color,
    input  logic               frame_end,
    input  logic               rd_hold,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_data,
    output logic               rd_data_valid,
    output logic               front_bank,
    output logic               frame_ready,
    output logic [CNT_W-1:0]   frame_count,
`ifdef GPU_CAPTURE_STATS_EN
    output logic [CNT_W-1:0]   clip_count,
    output logic [CNT_W-1:0]   drop_count,
`endif
    output logic               busy
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t             state_q;
    logic               front_bank_q;
    logic               frame_ready_q;
    logic [CNT_W-1:0]   frame_count_q;
    logic [CNT_W-1:0]   frame_count_d;
    logic               busy_q;
    logic [COLOR_W-1:0] rd_data_q;
    logic               rd_valid_q;

    logic [COLOR_W-1:0] bank0_q [DEPTH];
    logic [COLOR_W-1:0] bank1_q [DEPTH];

    logic               pix_s;
    logic               in_range_s;
    logic               wr_en_s;
    logic [ADDR_W-1:0]  wr_addr_s;
    logic               rd_in_range_s;

    // Pixel qualification, clipping and linear address generation
    always_comb begin
        pix_s         = pixel_valid & pixel_draw;
        in_range_s    = (32'(pixel_x) < 32'(H_RES)) && (32'(pixel_y) < 32'(V_RES));
        wr_en_s       = (state_q == ST_CAPTURE) & pix_s & in_range_s;
        wr_addr_s     = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
        rd_in_range_s = (32'(rd_addr) < 32'(DEPTH));
        frame_count_d = frame_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Capture FSM; a swap toggles the front bank, counts the frame and pulses frame_ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            front_bank_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= {CNT_W{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            frame_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_SYNC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_end) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (frame_end) begin
                        if (rd_hold) begin
                            state_q <= ST_HOLD;
                        end else begin
                            front_bank_q  <= ~front_bank_q;
                            frame_count_q <= frame_count_d;
                            frame_ready_q <= 1'b1;
                            if (!enable) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // The frame that ran during the hold is incomplete, so realign via SYNC
                    if (!rd_hold) begin
                        front_bank_q  <= ~front_bank_q;
                        frame_count_q <= frame_count_d;
                        frame_ready_q <= 1'b1;
                        if (enable) begin
                            state_q <= ST_SYNC;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Back-bank write port; memory contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            if (front_bank_q) begin
                bank0_q[wr_addr_s[IDX_W-1:0]] <= pixel_color;
            end else begin
                bank1_q[wr_addr_s[IDX_W-1:0]] <= pixel_color;
            end
        end
    end

    // Registered front-bank read; uses the pre-swap bank select when a swap coincides
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= {COLOR_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else if (rd_en) begin
            rd_valid_q <= 1'b1;
            if (!rd_in_range_s) begin
                rd_data_q <= {COLOR_W{1'b0}};
            end else if (front_bank_q) begin
                rd_data_q <= bank1_q[rd_addr[IDX_W-1:0]];
            end else begin
                rd_data_q <= bank0_q[rd_addr[IDX_W-1:0]];
            end
        end else begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= {COLOR_W{1'b0}};
        end
    end

`ifdef GPU_CAPTURE_STATS_EN
    logic [CNT_W-1:0] clip_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] clip_d;
    logic [CNT_W-1:0] drop_d;

    // Saturating increments for the statistics counters
    always_comb begin
        if (clip_q == {CNT_W{1'b1}}) begin
            clip_d = clip_q;
        end else begin
            clip_d = clip_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (drop_q == {CNT_W{1'b1}}) begin
            drop_d = drop_q;
        end else begin
            drop_d = drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Clip counts rejected pixels in CAPTURE; drop counts pixels seen in SYNC or HOLD
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clip_q <= {CNT_W{1'b0}};
            drop_q <= {CNT_W{1'b0}};
        end else begin
            if ((state_q == ST_CAPTURE) && pix_s && !in_range_s) begin
                clip_q <= clip_d;
            end
            if (((state_q == ST_SYNC) || (state_q == ST_HOLD)) && pix_s) begin
                drop_q <= drop_d;
            end
        end
    end

    assign clip_count = clip_q;
    assign drop_count = drop_q;
`endif

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign front_bank    = front_bank_q;
    assign frame_ready   = frame_ready_q;
    assign frame_count   = frame_count_q;
    assign busy          = busy_q;

endmodule

// File: doc/gpu_frame_capture.md
Name: gpu_frame_capture

Overview:
- Synthesizable, parametrised successor to the pixel-stream framebuffer sink used in simulation.
- Consumes the GPU wrapper pixel stream (valid/draw/x/y/color/frame_end), clips the coordinates and writes into a double-banked framebuffer.
- Swaps banks on frame_end and exposes the completed frame on a 1-cycle-latency read port for scanout or BMP readback.
- Sits between gpu_wrapper_vhdl and the display/readback logic.

Parameters:
- H_RES, 800, visible width in pixels
- V_RES, 600, visible height in pixels
- COLOR_W, 8, bits per pixel
- COORD_W, 11, width of the pixel_x / pixel_y inputs
- ADDR_W, 19, bank address width; must satisfy 2**ADDR_W >= H_RES*V_RES
- CNT_W, 16, width of the frame and statistics counters

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  capture enable
- pixel_valid  in  1  pixel stream qualifier
- pixel_draw  in  1  pixel is to be written
- pixel_x  in  COORD_W  pixel column
- pixel_y  in  COORD_W  pixel row
- pixel_color  in  COLOR_W  pixel value
- frame_end  in  1  single-cycle end-of-frame pulse
- rd_hold  in  1  reader lock; while high, the front bank must not change
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  linear read address, y*H_RES+x
- rd_data  out  COLOR_W  read data from the front bank
- rd_data_valid  out  1  rd_data is valid
- front_bank  out  1  index of the bank being displayed
- frame_ready  out  1  1-cycle pulse after each swap
- frame_count  out  CNT_W  number of completed swaps, wraps
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; front_bank=0; frame_ready=0; frame_count=0; rd_data=0; rd_data_valid=0; busy=0; statistics counters=0. Memory contents are not reset.
- States and transitions:
  - IDLE: all writes are ignored. Go to SYNC when enable=1.
  - SYNC: writes are ignored; waits for frame alignment. On frame_end go to CAPTURE. On enable=0 go to IDLE.
  - CAPTURE: write pixels to bank ~front_bank. On frame_end:
    - rd_hold=0: swap now. If enable=1 stay in CAPTURE, else go to IDLE.
    - rd_hold=1: go to HOLD.
    - enable=0 in mid-frame does not abort; the current frame completes first.
  - HOLD: writes are dropped. When rd_hold=0: swap, then go to SYNC (the partially missed frame is discarded), or to IDLE if enable=0.
- Swap, one register update: front_bank toggles, frame_count+1 (modulo 2**CNT_W), frame_ready=1 on the next cycle for exactly 1 cycle.
- Write condition: state==CAPTURE & pixel_valid & pixel_draw & pixel_x<H_RES & pixel_y<V_RES.
  - Address = pixel_y*H_RES+pixel_x, computed at ADDR_W width.
  - The write lands in the cycle the pixel is presented.
- Clipping: a pixel with valid & draw but out of range is never written and never aliases to another address.
- Pixel and frame_end in the same cycle: the pixel belongs to the ending frame and is written to the old back bank before the swap.
- Read: rd_en sampled at edge N gives rd_data/rd_data_valid at edge N+1, taken from front_bank as it stood at edge N.
  - rd_data_valid=0 whenever rd_en was 0.
  - rd_addr >= H_RES*V_RES returns 0 with rd_data_valid=1.
  - A read and a swap in the same cycle return old-front data.
- The read port works in every state, including IDLE.
- frame_end outside CAPTURE and HOLD has no effect other than the SYNC transition.

Optional Feature:
- Macro: GPU_CAPTURE_STATS_EN.
- Defined: adds outputs clip_count[CNT_W] (pixels rejected by clipping while in CAPTURE) and drop_count[CNT_W] (valid & draw pixels arriving in SYNC or HOLD). Both saturate at all-ones and are cleared only by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Bench parameters H_RES=8, V_RES=4, ADDR_W=5.
- Reset, enable=1, frame_end, then draw (3,2)=0xA5, then frame_end -> frame_ready pulses 1 cycle, front_bank=1, frame_count=1; read addr 19 gives 0xA5 one cycle after rd_en.
- In CAPTURE, draw (8,0) and (0,4) with color 0xFF -> no write; addr 0 and addr 31 unchanged; clip_count=2 if GPU_CAPTURE_STATS_EN.
- Pixel (1,1)=0x3C in the same cycle as frame_end -> after the swap, read addr 9 returns 0x3C from the new front bank.
- rd_hold=1 across frame_end, draw 5 pixels, release after 10 cycles -> swap occurs at release, state SYNC, the 5 pixels are not written, drop_count=5.
- Drop enable mid-frame, then frame_end -> swap happens, busy=0 next cycle, later pixels are ignored; assert reset mid-CAPTURE -> all outputs return to reset values immediately.
